// File: rtl/back_iconch_multi_interface_pkg.sv
// Shared types and default widths for the per-EU interconnect bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package back_iconch_multi_interface_pkg;

    // Default field widths; the top exposes them as overridable parameters.
    localparam int ICONCH_EUIDX_W = 3;
    localparam int ICONCH_DATA_W  = 16;
    localparam int ICONCH_ADDR_W  = 8;

    // TX request service states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } type_iconch_tx_state;

    // One RX FIFO entry at the default widths (data word plus its source address).
    typedef struct packed {
        logic [ICONCH_DATA_W-1:0] data;
        logic [ICONCH_ADDR_W-1:0] src_addr;
    } type_iconch_rx_entry;

endpackage

// File: rtl/back_iconch_multi_interface_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr.
// Latency: combinational, grant valid in the same cycle as req.
// Backpressure: none; the caller advances ptr only when a grant is consumed.
module back_iconch_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from ptr upward with wrap, taking the first active request.
    always_comb begin
        int c;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) c = c - N;
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = IW'(c);
            end
        end
    end

endmodule

// File: rtl/back_iconch_multi_interface.sv
// Per-EU bridge: RR-accepts channel writes into an RX FIFO, RR-serves channel reads to the EU.
// Latency: RX push->head 1 cycle; TX grant->eu_tx_valid_o 1 cycle, EU resp->channel strobe 1 cycle.
// Backpressure: RX losers/full see ich_success_o=0 and retry; TX requesters hold until strobe. Optional TX timeout via ICONCH_TX_TIMEOUT_EN.
module back_iconch_multi_interface
    import back_iconch_multi_interface_pkg::*;
#(
    parameter int EU_IDX   = 0,
    parameter int N_CH     = 2,
    parameter int DATA_W   = ICONCH_DATA_W,
    parameter int ADDR_W   = ICONCH_ADDR_W,
    parameter int EUIDX_W  = ICONCH_EUIDX_W,
    parameter int RX_DEPTH = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_CH-1:0]          ich_req_valid_i,
    input  logic [N_CH-1:0]          ich_data_valid_i,
    input  logic [N_CH*DATA_W-1:0]   ich_data_i,
    input  logic [N_CH-1:0]          ich_req_tx_valid_i,
    input  logic [N_CH*ADDR_W-1:0]   ich_src_addr_i,
    output logic [N_CH-1:0]          ich_success_o,
    output logic [N_CH*DATA_W-1:0]   ich_data_rx_o,
    output logic [N_CH-1:0]          ich_data_valid_rx_o,
    output logic                     eu_rx_valid_o,
    output logic [DATA_W-1:0]        eu_rx_data_o,
    output logic [ADDR_W-1:0]        eu_rx_addr_o,
    input  logic                     eu_rx_ready_i,
    output logic                     eu_tx_valid_o,
    output logic [ADDR_W-1:0]        eu_tx_src_addr_o,
    input  logic                     eu_tx_resp_valid_i,
    input  logic [DATA_W-1:0]        eu_tx_resp_data_i,
    output logic                     tx_timeout_o
);

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW = $clog2(RX_DEPTH);

    if (N_CH < 1 || RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0 || TIMEOUT < 1)
    begin : g_bad_cfg
        $error("back_iconch_multi_interface: invalid parameter set");
    end

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] src_addr;
    } rx_entry_t;

    // ------------------------------------------------------------------ RX path
    logic [N_CH-1:0] rx_req;
    logic [N_CH-1:0] rx_gnt;
    logic [IW-1:0]   rx_ptr;
    logic [IW-1:0]   rx_idx;
    logic            rx_any;

    assign rx_req = ich_req_valid_i & ich_data_valid_i;

    back_iconch_rr_arbiter #(.N(N_CH), .IW(IW)) u_rx_arb (
        .req   (rx_req),
        .ptr   (rx_ptr),
        .grant (rx_gnt),
        .idx   (rx_idx),
        .any   (rx_any)
    );

    rx_entry_t     fifo_mem [RX_DEPTH];
    rx_entry_t     push_entry;
    rx_entry_t     head_entry;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          rx_pop;
    logic          rx_push;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(RX_DEPTH));
    assign rx_pop     = !fifo_empty && eu_rx_ready_i;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    assign rx_push    = rx_any && (!fifo_full || rx_pop);

    assign ich_success_o       = rx_push ? rx_gnt : '0;
    assign push_entry.data     = ich_data_i[int'(rx_idx)*DATA_W +: DATA_W];
    assign push_entry.src_addr = ich_src_addr_i[int'(rx_idx)*ADDR_W +: ADDR_W];

    // FIFO storage; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (rx_push) fifo_mem[wr_ptr] <= push_entry;
    end

    // FIFO pointers, occupancy and RX round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rx_ptr <= '0;
        end else begin
            if (rx_push) begin
                wr_ptr <= wr_ptr + AW'(1);
                rx_ptr <= (int'(rx_idx) == N_CH - 1) ? '0 : rx_idx + IW'(1);
            end
            if (rx_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_entry    = fifo_mem[rd_ptr];
    assign eu_rx_valid_o = !fifo_empty;
    assign eu_rx_data_o  = fifo_empty ? '0 : head_entry.data;
    assign eu_rx_addr_o  = fifo_empty ? '0 : head_entry.src_addr;

    // ------------------------------------------------------------------ TX path
    logic [N_CH-1:0]     tx_req;
    logic [N_CH-1:0]     tx_gnt;
    logic [IW-1:0]       tx_ptr;
    logic [IW-1:0]       tx_idx;
    logic                tx_any;
    logic [ADDR_W-1:0]   tx_gnt_addr;
    type_iconch_tx_state state;
    type_iconch_tx_state next_state;
    logic [IW-1:0]       tx_ch;
    logic [ADDR_W-1:0]   tx_addr;
    logic [DATA_W-1:0]   tx_data;
    logic                tx_hold;
    logic                tx_expire;

    for (genvar k = 0; k < N_CH; k++) begin : g_tx_req
        assign tx_req[k] = ich_req_tx_valid_i[k] &&
            (ich_src_addr_i[k*ADDR_W + ADDR_W - 1 -: EUIDX_W] == EUIDX_W'(EU_IDX));
    end

    back_iconch_rr_arbiter #(.N(N_CH), .IW(IW)) u_tx_arb (
        .req   (tx_req),
        .ptr   (tx_ptr),
        .grant (tx_gnt),
        .idx   (tx_idx),
        .any   (tx_any)
    );

    // Select the granted channel's address from the one-hot grant.
    always_comb begin
        tx_gnt_addr = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (tx_gnt[k]) tx_gnt_addr = tx_gnt_addr | ich_src_addr_i[k*ADDR_W +: ADDR_W];
        end
    end

    assign tx_hold = ich_req_tx_valid_i[tx_ch];

`ifdef ICONCH_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tx_cnt;

    // Resp and withdrawal take priority over expiry.
    assign tx_expire = (state == BUSY) && !eu_tx_resp_valid_i && tx_hold &&
                       (tx_cnt == TW'(TIMEOUT - 1));

    // BUSY wait counter, cleared on entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_cnt <= '0;
        end else if (state == IDLE && tx_any) begin
            tx_cnt <= '0;
        end else if (state == BUSY) begin
            tx_cnt <= tx_cnt + TW'(1);
        end
    end
`else
    assign tx_expire = 1'b0;
`endif

    // TX state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // TX next-state: response beats withdrawal, withdrawal beats timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (tx_any) next_state = BUSY;
            BUSY: begin
                if (eu_tx_resp_valid_i) next_state = RESP;
                else if (!tx_hold)      next_state = IDLE;
                else if (tx_expire)     next_state = IDLE;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // TX datapath: latch request on grant, latch response data in BUSY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_ptr  <= '0;
            tx_ch   <= '0;
            tx_addr <= '0;
            tx_data <= '0;
        end else begin
            if (state == IDLE && tx_any) begin
                tx_ch   <= tx_idx;
                tx_addr <= tx_gnt_addr;
                tx_ptr  <= (int'(tx_idx) == N_CH - 1) ? '0 : tx_idx + IW'(1);
            end
            if (state == BUSY && eu_tx_resp_valid_i) tx_data <= eu_tx_resp_data_i;
        end
    end

    // TX outputs decoded from registered state and latched data.
    always_comb begin
        eu_tx_valid_o       = (state == BUSY);
        eu_tx_src_addr_o    = (state == BUSY) ? tx_addr : '0;
        ich_data_valid_rx_o = '0;
        ich_data_rx_o       = '0;
        tx_timeout_o        = tx_expire;
        if (state == RESP) begin
            ich_data_valid_rx_o[tx_ch]                  = 1'b1;
            ich_data_rx_o[int'(tx_ch)*DATA_W +: DATA_W] = tx_data;
        end
    end

endmodule
